// File: rtl/super_sys_ctrl_pkg.sv
// Shared types and constants for the super systolic array job sequencer.
package super_sys_ctrl_pkg;

    // Geometry of the 2x2 super systolic array driven by the sequencer.
    localparam int SUPER_SYS_ROWS = 4;
    localparam int SUPER_SYS_COLS = 4;
    localparam int SMALL_SYS_ROWS = 2;
    localparam int A_BITWIDTH     = 8;

    // Array operating modes selected by cfg_mode.
    localparam logic MODE_FUSED = 1'b0;
    localparam logic MODE_SPLIT = 1'b1;

    // Job sequencer states.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WLOAD = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } sctrl_state_t;

    // Latched job descriptor; the vector count is held separately because
    // its width follows the counter-width parameter of the instance.
    typedef struct packed {
        logic       mode;
        logic [7:0] wrows;
        logic       illegal;
    } sctrl_cfg_t;

    // A descriptor is unusable when it loads no weight rows, more rows than
    // the array has, or carries no activation vectors.
    function automatic logic cfg_illegal(input logic [7:0] wrows,
                                         input logic       nvec_zero,
                                         input logic [7:0] max_rows);
        return (wrows == 8'd0) || (wrows > max_rows) || nvec_zero;
    endfunction

endpackage

// File: rtl/super_sys_ctrl_skew_buf.sv
// Per-row activation skew line: row r is delayed r cycles behind row 0,
// and row 0 itself passes through one register. Each stage carries {en, data}.
// The whole line clears on the asynchronous reset or a synchronous flush.
module skew_buf #(
    parameter int ROWS = 4,
    parameter int DW   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 en_in,
    input  logic [ROWS*DW-1:0]   data_in,
    output logic [ROWS-1:0]      en_out,
    output logic [ROWS*DW-1:0]   data_out
);

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [DW:0] line_q [0:r];

        // Delay line for this row; always advances unless flushed.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i <= r; i++) begin
                    line_q[i] <= '0;
                end
            end else if (flush) begin
                for (int i = 0; i <= r; i++) begin
                    line_q[i] <= '0;
                end
            end else begin
                line_q[0] <= {en_in, data_in[r*DW +: DW]};
                for (int i = 1; i <= r; i++) begin
                    line_q[i] <= line_q[i-1];
                end
            end
        end

        assign en_out[r]             = line_q[r][DW];
        assign data_out[r*DW +: DW]  = line_q[r][DW-1:0];
    end

endmodule

// File: rtl/super_sys_ctrl.sv
// Job sequencer for the 2x2 super systolic array: latches a descriptor,
// holds the array mux selects for the job mode, runs weight load, streams
// skewed activations and counts output beats until the job drains.
// Optional build macro: SUPER_SYS_CTRL_PERF_EN adds busy/stall/drain
// cycle counters as extra read-only outputs.
module super_sys_ctrl
    import super_sys_ctrl_pkg::*;
#(
    parameter int ROWS  = SUPER_SYS_ROWS,
    parameter int COLS  = SUPER_SYS_COLS,
    parameter int CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        cfg_mode,
    input  logic [7:0]                  cfg_wrows,
    input  logic [CNT_W-1:0]            cfg_nvec,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic                        w_rd_en,
    output logic [COLS-1:0]             wfetch,
    input  logic                        act_valid,
    input  logic [ROWS*A_BITWIDTH-1:0]  act_data,
    output logic                        act_ready,
    output logic [ROWS-1:0]             if_en,
    output logic [ROWS*A_BITWIDTH-1:0]  if_data,
    output logic [SMALL_SYS_ROWS-1:0]   if_mux_sel,
    output logic [SUPER_SYS_ROWS-1:0]   w_mux_sel,
    input  logic                        arr_valid,
    output logic                        of_valid
`ifdef SUPER_SYS_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]            perf_busy_cyc,
    output logic [CNT_W-1:0]            perf_stall_cyc,
    output logic [CNT_W-1:0]            perf_drain_cyc
`endif
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    sctrl_state_t        state_q, state_d;
    sctrl_cfg_t          cfg_q, cfg_d;
    logic [CNT_W-1:0]    nvec_q, nvec_d;
    logic [7:0]          wcnt_q, wcnt_d;
    logic [CNT_W-1:0]    vcnt_q, vcnt_d;
    logic [CNT_W-1:0]    beat_q, beat_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                wfetch_q, wfetch_d;
    logic                feed_q, feed_d;
    logic                sel_q, sel_d;
    logic                ovalid_q, ovalid_d;

    logic                illegal_s;
    logic                beat_win_s;
    logic [CNT_W-1:0]    beat_sum_s;
    logic                flush_s;
    logic                accept_s;
    logic [ROWS*A_BITWIDTH-1:0] skew_data_s;

    assign illegal_s  = cfg_illegal(cfg_wrows, (cfg_nvec == CNT_ZERO), 8'(ROWS));
    // Beats only count while vectors can be in flight through the array.
    assign beat_win_s = (state_q == S_FEED) || (state_q == S_DRAIN);
    // Saturating beat count: extra beats past the maximum do not wrap.
    assign beat_sum_s = (beat_win_s && arr_valid && (beat_q != CNT_MAX))
                        ? (beat_q + CNT_W'(1)) : beat_q;

    // Next-state, counter and registered-output decode for the job FSM.
    always_comb begin
        state_d  = state_q;
        cfg_d    = cfg_q;
        nvec_d   = nvec_q;
        wcnt_d   = wcnt_q;
        vcnt_d   = vcnt_q;
        beat_d   = beat_q;
        flush_s  = 1'b0;
        accept_s = 1'b0;

        case (state_q)
            S_IDLE: begin
                wcnt_d = 8'd0;
                vcnt_d = CNT_ZERO;
                beat_d = CNT_ZERO;
                if (start) begin
                    cfg_d.mode    = cfg_mode;
                    cfg_d.wrows   = cfg_wrows;
                    cfg_d.illegal = illegal_s;
                    nvec_d        = cfg_nvec;
                    flush_s       = 1'b1;
                    state_d       = illegal_s ? S_DONE : S_WLOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WLOAD: begin
                wcnt_d = wcnt_q + 8'd1;
                if (wcnt_q == (cfg_q.wrows - 8'd1)) begin
                    state_d = S_FEED;
                end else begin
                    state_d = S_WLOAD;
                end
            end
            S_FEED: begin
                accept_s = act_valid;
                beat_d   = beat_sum_s;
                if (act_valid) begin
                    vcnt_d = vcnt_q + CNT_W'(1);
                    if (vcnt_q == (nvec_q - CNT_W'(1))) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_FEED;
                    end
                end else begin
                    state_d = S_FEED;
                end
            end
            S_DRAIN: begin
                beat_d = beat_sum_s;
                if (beat_sum_s >= nvec_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                // A job entered straight from IDLE (illegal descriptor) spends
                // one silent cycle here before its done pulse.
                if (done_q) begin
                    state_d = S_IDLE;
                    vcnt_d  = CNT_ZERO;
                    beat_d  = CNT_ZERO;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE) && (state_q != S_IDLE);
        err_d    = done_d && cfg_q.illegal;
        wfetch_d = (state_d == S_WLOAD);
        feed_d   = (state_d == S_FEED);
        sel_d    = (state_d != S_IDLE) && (cfg_d.mode == MODE_SPLIT);
        ovalid_d = beat_win_s && arr_valid;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Descriptor, counters and registered control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_q    <= '0;
            nvec_q   <= CNT_ZERO;
            wcnt_q   <= 8'd0;
            vcnt_q   <= CNT_ZERO;
            beat_q   <= CNT_ZERO;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            wfetch_q <= 1'b0;
            feed_q   <= 1'b0;
            sel_q    <= 1'b0;
            ovalid_q <= 1'b0;
        end else begin
            cfg_q    <= cfg_d;
            nvec_q   <= nvec_d;
            wcnt_q   <= wcnt_d;
            vcnt_q   <= vcnt_d;
            beat_q   <= beat_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            wfetch_q <= wfetch_d;
            feed_q   <= feed_d;
            sel_q    <= sel_d;
            ovalid_q <= ovalid_d;
        end
    end

    // Accepted vectors enter the skew line; idle FEED cycles push bubbles.
    assign skew_data_s = accept_s ? act_data : {(ROWS*A_BITWIDTH){1'b0}};

    skew_buf #(
        .ROWS (ROWS),
        .DW   (A_BITWIDTH)
    ) u_skew (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush_s),
        .en_in    (accept_s),
        .data_in  (skew_data_s),
        .en_out   (if_en),
        .data_out (if_data)
    );

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign w_rd_en    = wfetch_q;
    assign wfetch     = {COLS{wfetch_q}};
    // Ready is the valid gated by a registered FEED flag, so a vector is
    // consumed in the same cycle it is offered.
    assign act_ready  = feed_q & act_valid;
    assign if_mux_sel = {SMALL_SYS_ROWS{sel_q}};
    assign w_mux_sel  = {SUPER_SYS_ROWS{sel_q}};
    assign of_valid   = ovalid_q;

`ifdef SUPER_SYS_CTRL_PERF_EN
    logic [CNT_W-1:0] perf_busy_q;
    logic [CNT_W-1:0] perf_stall_q;
    logic [CNT_W-1:0] perf_drain_q;

    // Performance counters: cleared when a job is accepted, frozen after done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_busy_q  <= CNT_ZERO;
            perf_stall_q <= CNT_ZERO;
            perf_drain_q <= CNT_ZERO;
        end else if ((state_q == S_IDLE) && start) begin
            perf_busy_q  <= CNT_ZERO;
            perf_stall_q <= CNT_ZERO;
            perf_drain_q <= CNT_ZERO;
        end else begin
            if (busy_q) begin
                perf_busy_q <= perf_busy_q + CNT_W'(1);
            end
            if ((state_q == S_FEED) && !act_valid) begin
                perf_stall_q <= perf_stall_q + CNT_W'(1);
            end
            if (state_q == S_DRAIN) begin
                perf_drain_q <= perf_drain_q + CNT_W'(1);
            end
        end
    end

    assign perf_busy_cyc  = perf_busy_q;
    assign perf_stall_cyc = perf_stall_q;
    assign perf_drain_cyc = perf_drain_q;
`endif

endmodule

// File: tb/tb_super_sys_ctrl.sv
// Self-checking bench for super_sys_ctrl. Each job's expected waveform is
// derived from its descriptor and pre-drawn input patterns using the timing
// rules (fetch window, accept list, n-th beat, done cycle).
module tb_super_sys_ctrl;
    import super_sys_ctrl_pkg::*;

    localparam int ROWS  = SUPER_SYS_ROWS;
    localparam int COLS  = SUPER_SYS_COLS;
    localparam int CNT_W = 16;
    localparam int AW    = A_BITWIDTH;
    localparam int GAP   = 8;
    localparam int N     = 160;

    logic                     clk, rst, start, cfg_mode;
    logic [7:0]               cfg_wrows;
    logic [CNT_W-1:0]         cfg_nvec;
    logic                     busy, done, err, w_rd_en;
    logic [COLS-1:0]          wfetch;
    logic                     act_valid, act_ready, arr_valid, of_valid;
    logic [ROWS*AW-1:0]       act_data, if_data;
    logic [ROWS-1:0]          if_en;
    logic [SMALL_SYS_ROWS-1:0] if_mux_sel;
    logic [SUPER_SYS_ROWS-1:0] w_mux_sel;
`ifdef SUPER_SYS_CTRL_PERF_EN
    logic [CNT_W-1:0]         perf_busy_cyc, perf_stall_cyc, perf_drain_cyc;
`endif

    super_sys_ctrl #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_mode(cfg_mode),
        .cfg_wrows(cfg_wrows), .cfg_nvec(cfg_nvec), .busy(busy), .done(done),
        .err(err), .w_rd_en(w_rd_en), .wfetch(wfetch), .act_valid(act_valid),
        .act_data(act_data), .act_ready(act_ready), .if_en(if_en),
        .if_data(if_data), .if_mux_sel(if_mux_sel), .w_mux_sel(w_mux_sel),
        .arr_valid(arr_valid), .of_valid(of_valid)
`ifdef SUPER_SYS_CTRL_PERF_EN
        , .perf_busy_cyc(perf_busy_cyc), .perf_stall_cyc(perf_stall_cyc),
        .perf_drain_cyc(perf_drain_cyc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Per-job stimulus and reference arrays, indexed by cycle relative to start.
    bit                 av  [N];
    bit                 bv  [N];
    bit                 st  [N];
    bit                 acc [N];
    logic [ROWS*AW-1:0] ad  [N];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_wrd"}, w_rd_en, 0);
        chk({tag, "_wfetch"}, wfetch, 0);
        chk({tag, "_ready"}, act_ready, 0);
        chk({tag, "_ifen"}, if_en, 0);
        chk({tag, "_ifdata"}, if_data, 0);
        chk({tag, "_ifsel"}, if_mux_sel, 0);
        chk({tag, "_wsel"}, w_mux_sel, 0);
        chk({tag, "_ofv"}, of_valid, 0);
    endtask

    // av_mode: 0 random, 1 always valid, 2 toggle 1,0,..., 3 pattern 1,0,1,0,1,1...
    // bv_mode: 0 random beats, 1 last beats end exactly on the last accept.
    task automatic run_job(input logic mode, input int w, input int n,
                           input int av_mode, input int bv_mode, input int abort_at);
        int  fs, L, c, D, cnt, p, stalls, j;
        bit  illegal;
        logic [ROWS-1:0]    e_en;
        logic [ROWS*AW-1:0] e_dat;
        logic [COLS-1:0]    ones_c;
        logic [SMALL_SYS_ROWS-1:0] ones_i;
        logic [SUPER_SYS_ROWS-1:0] ones_w;

        ones_c  = '1;
        ones_i  = '1;
        ones_w  = '1;
        illegal = (w == 0) || (w > ROWS) || (n == 0);
        fs      = w + 1;
        for (int k = 0; k < N; k++) begin
            p = k - fs;
            if (k < fs || av_mode == 0) av[k] = ($urandom_range(0, 99) < 70);
            else if (av_mode == 1)      av[k] = 1'b1;
            else if (av_mode == 2)      av[k] = (p % 2 == 0);
            else                        av[k] = !(p == 1 || p == 3);
            bv[k]  = ($urandom_range(0, 99) < 40);
            ad[k]  = $urandom;
            acc[k] = 1'b0;
        end
        L = -1; c = -1; stalls = 0;
        if (illegal) begin
            D = 2;
        end else begin
            cnt = 0;
            for (int k = fs; cnt < n; k++) begin
                if (k >= N - 40) av[k] = 1'b1;
                if (av[k]) begin acc[k] = 1'b1; cnt++; L = k; end
                else stalls++;
            end
            if (bv_mode == 1) begin
                for (int k = fs; k < N; k++) bv[k] = 1'b0;
                for (int k = L - n + 1; k <= L; k++) bv[k] = 1'b1;
                c = L;
            end else begin
                cnt = 0;
                for (int k = fs; cnt < n; k++) begin
                    if (k >= N - 40) bv[k] = 1'b1;
                    if (bv[k]) begin cnt++; c = k; end
                end
            end
            D = (L + 2 > c + 1) ? L + 2 : c + 1;
        end
        for (int k = 0; k < N; k++) st[k] = (k == 0) ? 1'b1 : (k <= D) && ($urandom_range(0, 3) == 0);

        for (int k = 0; k <= D + GAP; k++) begin
            @(posedge clk);
            #1;
            start     = st[k];
            cfg_mode  = (k == 0) ? mode : 1'($urandom);
            cfg_wrows = (k == 0) ? 8'(w) : 8'($urandom);
            cfg_nvec  = (k == 0) ? CNT_W'(n) : CNT_W'($urandom_range(0, 20));
            act_valid = av[k];
            act_data  = ad[k];
            arr_valid = bv[k];
            if (abort_at > 0 && k == abort_at) begin
                rst = 1'b1;
                #1;
                chk_quiet("abort");
                @(posedge clk);
                #1;
                rst = 1'b0; start = 1'b0; act_valid = 1'b0; arr_valid = 1'b0;
                for (int q = 0; q < 6; q++) begin
                    @(negedge clk);
                    chk("abort_nodone", done, 0);
                    chk("abort_idle", busy, 0);
                    chk("abort_ifen", if_en, 0);
                end
                return;
            end
            @(negedge clk);
            chk("busy", busy, (k >= 1 && k <= D));
            chk("done", done, (k == D));
            chk("err", err, (k == D) && illegal);
            chk("w_rd_en", w_rd_en, !illegal && k >= 1 && k <= w);
            chk("wfetch", wfetch, (!illegal && k >= 1 && k <= w) ? ones_c : '0);
            chk("if_mux_sel", if_mux_sel, (k >= 1 && k <= D && mode) ? ones_i : '0);
            chk("w_mux_sel", w_mux_sel, (k >= 1 && k <= D && mode) ? ones_w : '0);
            chk("act_ready", act_ready, acc[k]);
            chk("of_valid", of_valid, !illegal && k >= 1 && bv[k-1] && (k - 1 >= fs) && (k - 1 <= D - 1));
            e_en = '0; e_dat = '0;
            for (int r = 0; r < ROWS; r++) begin
                j = k - 1 - r;
                if (j >= 0 && acc[j]) begin
                    e_en[r] = 1'b1;
                    e_dat[r*AW +: AW] = ad[j][r*AW +: AW];
                end
            end
            chk("if_en", if_en, e_en);
            chk("if_data", if_data, e_dat);
        end
`ifdef SUPER_SYS_CTRL_PERF_EN
        chk("perf_busy", perf_busy_cyc, D);
        chk("perf_stall", perf_stall_cyc, illegal ? 0 : stalls);
        chk("perf_drain", perf_drain_cyc, illegal ? 0 : D - 1 - L);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; cfg_mode = 1'b0; cfg_wrows = 8'd0;
        cfg_nvec = '0; act_valid = 1'b0; act_data = '0; arr_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        run_job(MODE_FUSED, 4, 3, 1, 0, 0);       // baseline fused job
        run_job(MODE_SPLIT, 3, 4, 2, 0, 0);       // bubbles every other cycle
        run_job(MODE_FUSED, 2, 0, 0, 0, 0);       // nvec = 0
        run_job(MODE_SPLIT, ROWS + 1, 3, 0, 0, 0); // too many weight rows
        run_job(MODE_FUSED, 2, 4, 0, 1, 0);       // last beat on last accept
        run_job(MODE_FUSED, 4, 6, 1, 0, 6);       // reset mid-FEED
        run_job(MODE_SPLIT, 1, 2, 0, 0, 0);       // normal job after abort
        run_job(MODE_FUSED, 2, 4, 3, 0, 0);       // two stall cycles
        for (int i = 0; i < 25; i++) begin
            run_job(1'($urandom), $urandom_range(0, ROWS + 1), $urandom_range(0, 8),
                    0, $urandom_range(0, 1), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
